neopixel_frame_sequencer: RTL and testbench

- Sequences the NeoPixel strand controller frame by frame for a single-lit-pixel "chaser" pattern.
- Each frame, it walks every pixel and colour channel through the controller's load handshake, then issues the send.
- After the send, it enforces a latch gap and a fixed frame period, then advances the lit position.
- Sits between top-level user controls and the strand controller.

---
 rtl/neopixel_frame_sequencer.sv | 247 ++++++++++++++++++++++++
 tb/tb_neopixel_frame_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neopixel_frame_sequencer.sv
// ---------------------------------------------------------------------------
// neopixel_frame_sequencer
//
// Drives a NeoPixel strand controller frame by frame with a single-lit-pixel
// "chaser" pattern. Each frame loads every pixel's green/red/blue channel
// through the controller's load handshake, issues one send, waits for the
// transmission to finish, enforces a latch gap and a fixed frame period,
// and then advances the lit position.
//
// Parameters:
//   NUM_PIXELS    pixels on the strand (2..8), must match the controller
//   FRAME_CYCLES  clock cycles per frame period
//   LATCH_CYCLES  minimum idle cycles after transmission completes
//
// Ports:
//   clock          system clock
//   reset          asynchronous, active-low reset
//   enable         run the sequence; sampled only at frame boundaries
//   base_level     brightness of the lit pixel, captured at frame start
//   ready_to_load  controller can accept a colour value this cycle
//   ready_to_send  controller is idle / able to start a transmission
//   color_level    colour value presented with load_color
//   color_index    00 = red, 01 = blue, 10 = green
//   pixel_index    target pixel of the current load
//   load_color     one-cycle load strobe
//   send_it        one-cycle send strobe
//   busy           high whenever the sequencer is not idle
//   frame_done     one-cycle pulse as the frame period ends
//
// Build option:
//   SEQ_BOUNCE_EN  when defined, the lit pixel ping-pongs across the strand
//                  instead of wrapping; the colour rotates on each return to
//                  pixel 0.
// ---------------------------------------------------------------------------
module neopixel_frame_sequencer #(
    parameter int NUM_PIXELS   = 5,
    parameter int FRAME_CYCLES = 2500000,
    parameter int LATCH_CYCLES = 2500
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       enable,
    input  logic [7:0] base_level,
    input  logic       ready_to_load,
    input  logic       ready_to_send,
    output logic [7:0] color_level,
    output logic [1:0] color_index,
    output logic [2:0] pixel_index,
    output logic       load_color,
    output logic       send_it,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SEND    = 3'd2;
    localparam logic [2:0] S_WAIT_LO = 3'd3;
    localparam logic [2:0] S_WAIT_HI = 3'd4;
    localparam logic [2:0] S_HOLD    = 3'd5;

    localparam logic [1:0] CH_RED   = 2'b00;
    localparam logic [1:0] CH_BLUE  = 2'b01;
    localparam logic [1:0] CH_GREEN = 2'b10;

    localparam int FT_W = $clog2(FRAME_CYCLES + 1);
    localparam int LT_W = $clog2(LATCH_CYCLES + 1);
    localparam logic [FT_W-1:0] FRAME_LAST = FT_W'(FRAME_CYCLES - 1);
    localparam logic [LT_W-1:0] LATCH_LAST = LT_W'(LATCH_CYCLES - 1);
    localparam logic [FT_W-1:0] FT_ONE     = FT_W'(1);
    localparam logic [LT_W-1:0] LT_ONE     = LT_W'(1);
    localparam logic [2:0]      PIX_LAST   = 3'(NUM_PIXELS - 1);

    logic [2:0]      state;
    logic [7:0]      level_q;
    logic [FT_W-1:0] frame_timer;
    logic [LT_W-1:0] latch_timer;
    logic [2:0]      load_pix;
    logic [1:0]      load_phase;
    logic [2:0]      pos;
    logic [1:0]      chan;
    logic [7:0]      held_level;
    logic [1:0]      held_index;
    logic [2:0]      held_pixel;

    logic [1:0]      phase_index;
    logic [7:0]      load_level;
    logic            load_last;
    logic            hold_exit;
    logic            start_frame;
    logic [2:0]      next_pos;
    logic [1:0]      next_chan;

`ifdef SEQ_BOUNCE_EN
    logic            dir_up;
    logic            next_dir_up;
`endif

    function automatic logic [1:0] rotate_chan(input logic [1:0] c);
        case (c)
            CH_RED:   rotate_chan = CH_GREEN;
            CH_GREEN: rotate_chan = CH_BLUE;
            default:  rotate_chan = CH_RED;
        endcase
    endfunction

    // Channel order within a pixel is green, red, blue (wire order of the strand).
    always_comb begin
        case (load_phase)
            2'd0:    phase_index = CH_GREEN;
            2'd1:    phase_index = CH_RED;
            default: phase_index = CH_BLUE;
        endcase
    end

    assign load_level  = (load_pix == pos && phase_index == chan) ? level_q : 8'd0;
    assign load_last   = (load_pix == PIX_LAST) && (load_phase == 2'd2);
    assign hold_exit   = (state == S_HOLD) && (latch_timer >= LATCH_LAST) &&
                         (frame_timer == FRAME_LAST);
    assign start_frame = enable && ((state == S_IDLE) || hold_exit);

    // Strobes are combinational so data is valid in the same cycle the
    // controller signals ready; between strobes the last load is held.
    assign load_color  = (state == S_LOAD) && ready_to_load;
    assign send_it     = (state == S_SEND) && ready_to_send;
    assign busy        = (state != S_IDLE);
    assign frame_done  = hold_exit;
    assign color_level = load_color ? load_level  : held_level;
    assign color_index = load_color ? phase_index : held_index;
    assign pixel_index = load_color ? load_pix    : held_pixel;

    // Lit-position advance applied when the frame ends.
    always_comb begin
        next_pos  = pos;
        next_chan = chan;
`ifdef SEQ_BOUNCE_EN
        next_dir_up = dir_up;
        if (dir_up) begin
            next_pos = pos + 3'd1;
            if (pos + 3'd1 == PIX_LAST) begin
                next_dir_up = 1'b0;
            end
        end else begin
            next_pos = pos - 3'd1;
            if (pos == 3'd1) begin
                next_dir_up = 1'b1;
                next_chan   = rotate_chan(chan);
            end
        end
`else
        if (pos == PIX_LAST) begin
            next_pos  = 3'd0;
            next_chan = rotate_chan(chan);
        end else begin
            next_pos = pos + 3'd1;
        end
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            level_q     <= 8'd0;
            frame_timer <= '0;
            latch_timer <= '0;
            load_pix    <= 3'd0;
            load_phase  <= 2'd0;
            pos         <= 3'd0;
            chan        <= CH_RED;
            held_level  <= 8'd0;
            held_index  <= 2'd0;
            held_pixel  <= 3'd0;
`ifdef SEQ_BOUNCE_EN
            dir_up      <= 1'b1;
`endif
        end else begin
            // Frame timer runs from frame start and saturates so HOLD can
            // still exit when loading plus transmission overruns the period.
            if (state != S_IDLE && frame_timer != FRAME_LAST) begin
                frame_timer <= frame_timer + FT_ONE;
            end

            case (state)
                S_IDLE: begin
                    if (enable) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (ready_to_load) begin
                        held_level <= load_level;
                        held_index <= phase_index;
                        held_pixel <= load_pix;
                        if (load_last) begin
                            state      <= S_SEND;
                            load_pix   <= 3'd0;
                            load_phase <= 2'd0;
                        end else if (load_phase == 2'd2) begin
                            load_phase <= 2'd0;
                            load_pix   <= load_pix + 3'd1;
                        end else begin
                            load_phase <= load_phase + 2'd1;
                        end
                    end
                end
                S_SEND: begin
                    if (ready_to_send) begin
                        state <= S_WAIT_LO;
                    end
                end
                S_WAIT_LO: begin
                    if (!ready_to_send) begin
                        state <= S_WAIT_HI;
                    end
                end
                S_WAIT_HI: begin
                    if (ready_to_send) begin
                        state       <= S_HOLD;
                        latch_timer <= '0;
                    end
                end
                S_HOLD: begin
                    if (latch_timer != LATCH_LAST) begin
                        latch_timer <= latch_timer + LT_ONE;
                    end
                    if (hold_exit) begin
                        pos  <= next_pos;
                        chan <= next_chan;
`ifdef SEQ_BOUNCE_EN
                        dir_up <= next_dir_up;
`endif
                        state <= enable ? S_LOAD : S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase

            if (start_frame) begin
                level_q     <= base_level;
                frame_timer <= '0;
                load_pix    <= 3'd0;
                load_phase  <= 2'd0;
            end
        end
    end

endmodule

// File: tb/tb_neopixel_frame_sequencer.sv
// ---------------------------------------------------------------------------
// tb_neopixel_frame_sequencer
//
// Scoreboard bench for neopixel_frame_sequencer (NUM_PIXELS=3,
// FRAME_CYCLES=200, LATCH_CYCLES=10). The stimulus process queues the
// expected load/send/frame_done events per frame; a monitor process pops
// and compares them as the DUT presents strobes. A small controller model
// answers the load/send handshake. Honors SEQ_BOUNCE_EN for the expected
// lit-pixel order.
// ---------------------------------------------------------------------------
module tb_neopixel_frame_sequencer;

    localparam int N_PIX   = 3;
    localparam int FRAME_C = 200;
    localparam int LATCH_C = 10;

    localparam int K_NONE = 0;
    localparam int K_LOAD = 1;
    localparam int K_SEND = 2;
    localparam int K_DONE = 3;

    localparam logic [1:0] RED   = 2'b00;
    localparam logic [1:0] BLUE  = 2'b01;
    localparam logic [1:0] GREEN = 2'b10;

    typedef struct {
        int         kind;
        logic [2:0] pix;
        logic [1:0] idx;
        logic [7:0] lvl;
        int         period;
        int         gap;
    } exp_item_t;

    logic       clock;
    logic       reset;
    logic       enable;
    logic [7:0] base_level;
    logic       ready_to_load;
    logic       ready_to_send;
    logic [7:0] color_level;
    logic [1:0] color_index;
    logic [2:0] pixel_index;
    logic       load_color;
    logic       send_it;
    logic       busy;
    logic       frame_done;

    exp_item_t  exp_q[$];
    int         cyc = 0;
    int         pass_count = 0;
    int         check_count = 0;
    int         done_count = 0;
    int         ready_ret_cyc = 0;
    int         drop_len = 20;
    logic       toggle_load = 1'b0;
    logic       timeout_hit = 1'b0;
    logic       final_req = 1'b0;
    logic       final_ack = 1'b0;
    int         pat_pos[8];
    logic [1:0] pat_chan[8];

    neopixel_frame_sequencer #(
        .NUM_PIXELS   (N_PIX),
        .FRAME_CYCLES (FRAME_C),
        .LATCH_CYCLES (LATCH_C)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .base_level    (base_level),
        .ready_to_load (ready_to_load),
        .ready_to_send (ready_to_send),
        .color_level   (color_level),
        .color_index   (color_index),
        .pixel_index   (pixel_index),
        .load_color    (load_color),
        .send_it       (send_it),
        .busy          (busy),
        .frame_done    (frame_done)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input int actual, input int expected);
        check_count++;
        if (actual == expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    function automatic exp_item_t next_item();
        exp_item_t none;
        none.kind = K_NONE;
        none.pix = 3'd0;
        none.idx = 2'd0;
        none.lvl = 8'd0;
        none.period = 0;
        none.gap = 0;
        if (exp_q.size() == 0) return none;
        return exp_q.pop_front();
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    // Queue one full frame: 9 loads in G,R,B order per pixel, one send, one frame_done.
    task automatic apply_stimulus(input int lit_pos, input logic [1:0] lit_chan,
                                  input logic [7:0] level, input int period, input int gap);
        exp_item_t item;
        logic [1:0] idx;
        for (int p = 0; p < N_PIX; p++) begin
            for (int ph = 0; ph < 3; ph++) begin
                idx = (ph == 0) ? GREEN : ((ph == 1) ? RED : BLUE);
                item.kind = K_LOAD;
                item.pix = 3'(p);
                item.idx = idx;
                item.lvl = (p == lit_pos && idx == lit_chan) ? level : 8'd0;
                item.period = 0;
                item.gap = 0;
                exp_q.push_back(item);
            end
        end
        item.kind = K_SEND;
        item.pix = 3'd0;
        item.idx = 2'd0;
        item.lvl = 8'd0;
        exp_q.push_back(item);
        item.kind = K_DONE;
        item.period = period;
        item.gap = gap;
        exp_q.push_back(item);
    endtask

    task automatic wait_done(input int target, input int budget);
        int waited = 0;
        while (done_count < target && waited < budget) begin
            step(1);
            waited++;
        end
        if (done_count < target) begin
            timeout_hit = 1'b1;
            $display("[TB] timed out waiting for frame %0d", target);
        end
    endtask

    // Strand controller model: ready_to_load always high or toggling;
    // ready_to_send drops for drop_len cycles after each send_it.
    initial begin
        logic saw_send;
        int   drop_cnt;
        drop_cnt = 0;
        ready_to_load = 1'b1;
        ready_to_send = 1'b1;
        forever begin
            @(negedge clock);
            saw_send = send_it;
            @(posedge clock);
            #1;
            ready_to_load = toggle_load ? ~ready_to_load : 1'b1;
            if (saw_send) begin
                ready_to_send = 1'b0;
                drop_cnt = drop_len;
            end else if (drop_cnt > 0) begin
                drop_cnt--;
                if (drop_cnt == 0) begin
                    ready_to_send = 1'b1;
                    ready_ret_cyc = cyc;
                end
            end
        end
    end

    // Monitor: pops the scoreboard on every strobe and checks reset/hold rules.
    initial begin
        exp_item_t  item;
        logic       prev_reset;
        logic       expect_idle;
        logic [7:0] held_level;
        logic [1:0] held_index;
        logic [2:0] held_pixel;
        int         last_done_cyc;
        prev_reset = 1'b0;
        expect_idle = 1'b0;
        held_level = 8'd0;
        held_index = 2'd0;
        held_pixel = 3'd0;
        last_done_cyc = 0;
        forever begin
            @(negedge clock);
            if (final_req && !final_ack) begin
                check_output("queue_drained", exp_q.size(), 0);
                check_output("no_timeout", int'(timeout_hit), 0);
                final_ack = 1'b1;
            end
            if (!reset) begin
                check_output("reset_outputs",
                    int'({load_color, send_it, busy, frame_done, color_level, color_index, pixel_index}), 0);
                held_level = 8'd0;
                held_index = 2'd0;
                held_pixel = 3'd0;
                expect_idle = 1'b0;
            end else begin
                if (!prev_reset) begin
                    check_output("post_reset_strobes", int'({load_color, send_it}), 0);
                end
                if (expect_idle) begin
                    check_output("busy_after_done", int'(busy), 0);
                    expect_idle = 1'b0;
                end
                if (load_color || send_it) begin
                    check_output("strobe_overlap", int'(load_color & send_it), 0);
                end
                if (load_color) begin
                    item = next_item();
                    check_output("load_kind", item.kind, K_LOAD);
                    check_output("load_ready", int'(ready_to_load), 1);
                    check_output("pixel_index", int'(pixel_index), int'(item.pix));
                    check_output("color_index", int'(color_index), int'(item.idx));
                    check_output("color_level", int'(color_level), int'(item.lvl));
                    held_level = item.lvl;
                    held_index = item.idx;
                    held_pixel = item.pix;
                end else begin
                    check_output("held_outputs", int'({color_level, color_index, pixel_index}),
                                 int'({held_level, held_index, held_pixel}));
                end
                if (send_it) begin
                    item = next_item();
                    check_output("send_kind", item.kind, K_SEND);
                end
                if (frame_done) begin
                    item = next_item();
                    check_output("done_kind", item.kind, K_DONE);
                    if (item.period != 0) begin
                        check_output("frame_period", cyc - last_done_cyc, item.period);
                    end
                    if (item.gap != 0) begin
                        check_output("latch_gap", cyc - ready_ret_cyc, item.gap);
                    end
                    last_done_cyc = cyc;
                    done_count++;
                    if (!enable) expect_idle = 1'b1;
                end
            end
            prev_reset = reset;
        end
    end

    // Stimulus
    initial begin
`ifdef SEQ_BOUNCE_EN
        pat_pos  = '{0, 1, 2, 1, 0, 1, 2, 1};
        pat_chan = '{RED, RED, RED, RED, GREEN, GREEN, GREEN, GREEN};
`else
        pat_pos  = '{0, 1, 2, 0, 1, 2, 0, 1};
        pat_chan = '{RED, RED, RED, GREEN, GREEN, GREEN, BLUE, BLUE};
`endif
        reset = 1'b0;
        enable = 1'b0;
        base_level = 8'h40;
        step(3);
        reset = 1'b1;
        step(2);

        $display("[TB] four frames, ready_to_load held high");
        apply_stimulus(pat_pos[0], pat_chan[0], 8'h40, 0, 0);
        for (int f = 1; f < 4; f++) apply_stimulus(pat_pos[f], pat_chan[f], 8'h40, FRAME_C, 0);
        enable = 1'b1;
        wait_done(3, 1000);
        enable = 1'b0;
        wait_done(4, 400);

        $display("[TB] two frames, ready_to_load toggling");
        base_level = 8'hA5;
        toggle_load = 1'b1;
        apply_stimulus(pat_pos[4], pat_chan[4], 8'hA5, 0, 0);
        apply_stimulus(pat_pos[5], pat_chan[5], 8'hA5, FRAME_C, 0);
        enable = 1'b1;
        wait_done(5, 400);
        enable = 1'b0;
        wait_done(6, 400);
        toggle_load = 1'b0;

        $display("[TB] long transmission, latch gap sets frame end");
        base_level = 8'h40;
        drop_len = 250;
        apply_stimulus(pat_pos[6], pat_chan[6], 8'h40, 0, LATCH_C);
        enable = 1'b1;
        step(2);
        enable = 1'b0;
        base_level = 8'h11;
        wait_done(7, 600);
        drop_len = 20;

        $display("[TB] reset during LOAD, then restart");
        toggle_load = 1'b1;
        apply_stimulus(pat_pos[7], pat_chan[7], 8'h11, 0, 0);
        enable = 1'b1;
        step(6);
        reset = 1'b0;
        exp_q.delete();
        base_level = 8'h40;
        apply_stimulus(0, RED, 8'h40, 0, 0);
        step(3);
        reset = 1'b1;
        step(2);
        enable = 1'b0;
        wait_done(8, 400);
        toggle_load = 1'b0;
        step(2);

        final_req = 1'b1;
        for (int i = 0; i < 5 && !final_ack; i++) step(1);
        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
